ham_deco: RTL and testbench

Hamming SEC decoder for the 12-bit codewords produced by the upstream 8-bit Hamming encoder. It sits on the RAM read path: it accepts stored codewords, computes the 4-bit syndrome, corrects any single-bit error, and returns 8 data bits. It is a 2-stage valid/ready pipeline with error flags and saturating error-event counters.

---
 rtl/ham_deco.sv | 88 ++++++++
 tb/tb_ham_deco.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ham_deco.sv
// ham_deco: Hamming(12,8) SEC decoder for the RAM read path.
// Two-stage valid/ready pipeline with error flags and saturating error-event counters.
module ham_deco #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [11:0]      i_code,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_err_corr,
    output logic             o_err_uncorr,
    output logic [3:0]       o_syndrome,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_corr_cnt,
    output logic [CNT_W-1:0] o_uncorr_cnt
);
    logic        s1_valid;
    logic [11:0] s1_code;
    logic [3:0]  s1_syn;
    logic [3:0]  syn;
    logic [11:0] fixed;
    logic        adv1, adv2, s1_corr, s1_uncorr, out_hs;

    always_comb begin
        syn[0] = ^{i_code[0], i_code[2], i_code[4], i_code[6], i_code[8], i_code[10]};
        syn[1] = ^{i_code[1], i_code[2], i_code[5], i_code[6], i_code[9], i_code[10]};
        syn[2] = ^{i_code[3], i_code[4], i_code[5], i_code[6], i_code[11]};
        syn[3] = ^{i_code[7], i_code[8], i_code[9], i_code[10], i_code[11]};
    end

    assign adv2      = !o_valid || i_ready;
    assign adv1      = !s1_valid || adv2;
    assign o_ready   = adv1;
    assign out_hs    = o_valid && i_ready;
    assign s1_corr   = s1_syn != 4'd0 && s1_syn <= 4'd12;
    assign s1_uncorr = s1_syn >= 4'd13;
    // syndrome s names Hamming position s, which lives at codeword bit s-1
    assign fixed     = s1_corr ? s1_code ^ (12'd1 << (s1_syn - 4'd1)) : s1_code;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid     <= 1'b0;
            s1_code      <= '0;
            s1_syn       <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_syndrome   <= '0;
            o_err_corr   <= 1'b0;
            o_err_uncorr <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= i_valid;
                if (i_valid) begin
                    s1_code <= i_code;
                    s1_syn  <= syn;
                end
            end
            if (adv2) begin
                o_valid <= s1_valid;
                if (s1_valid) begin
                    o_data       <= {fixed[11:8], fixed[6:4], fixed[2]};
                    o_syndrome   <= s1_syn;
                    o_err_corr   <= s1_corr;
                    o_err_uncorr <= s1_uncorr;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_corr_cnt   <= '0;
            o_uncorr_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_corr_cnt   <= '0;
            o_uncorr_cnt <= '0;
        end else if (out_hs) begin
            if (o_err_corr && o_corr_cnt != '1)
                o_corr_cnt <= o_corr_cnt + CNT_W'(1);
            if (o_err_uncorr && o_uncorr_cnt != '1)
                o_uncorr_cnt <= o_uncorr_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ham_deco.sv
// tb_ham_deco: directed table-driven bench for ham_deco with CNT_W = 2,
// plus hand-written backpressure, counter-clear and async-reset sequences.
module tb_ham_deco;
    localparam int CNT_W = 2;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [11:0]      i_code = '0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [7:0]       o_data;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic             o_err_corr;
    logic             o_err_uncorr;
    logic [3:0]       o_syndrome;
    logic             i_cnt_clr = 1'b0;
    logic [CNT_W-1:0] o_corr_cnt;
    logic [CNT_W-1:0] o_uncorr_cnt;

    ham_deco #(.CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_code(i_code), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_err_corr(o_err_corr), .o_err_uncorr(o_err_uncorr), .o_syndrome(o_syndrome),
        .i_cnt_clr(i_cnt_clr), .o_corr_cnt(o_corr_cnt), .o_uncorr_cnt(o_uncorr_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [11:0] code;
        logic [7:0]  data;
        logic [3:0]  syn;
        logic        corr;
        logic        uncorr;
        logic [1:0]  ccnt;
        logic [1:0]  ucnt;
    } vec_t;

    vec_t tv[9];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic run_vec(input vec_t v, input logic clr, input int idx);
        i_code  = v.code;
        i_valid = 1'b1;
        i_ready = 1'b1;
        #1 chk($sformatf("ready_idle[%0d]", idx), o_ready, 1);
        tick;
        i_valid = 1'b0;
        chk($sformatf("latency_early[%0d]", idx), o_valid, 0);
        tick;
        chk($sformatf("valid[%0d]", idx), o_valid, 1);
        chk($sformatf("data[%0d]", idx), o_data, v.data);
        chk($sformatf("syndrome[%0d]", idx), o_syndrome, v.syn);
        chk($sformatf("err_corr[%0d]", idx), o_err_corr, v.corr);
        chk($sformatf("err_uncorr[%0d]", idx), o_err_uncorr, v.uncorr);
        i_cnt_clr = clr;
        tick;
        i_cnt_clr = 1'b0;
        chk($sformatf("valid_drop[%0d]", idx), o_valid, 0);
        chk($sformatf("corr_cnt[%0d]", idx), o_corr_cnt, v.ccnt);
        chk($sformatf("uncorr_cnt[%0d]", idx), o_uncorr_cnt, v.ucnt);
    endtask

    initial begin
        logic [11:0] bw[4];
        logic [7:0]  bd[4];
        logic [7:0]  held;
        logic        stalled, saw_full;
        int          in_i, out_i;
        vec_t        v;

        tv[0] = '{12'hA27, 8'hA5, 4'd0,  1'b0, 1'b0, 2'd0, 2'd0};
        tv[1] = '{12'hA67, 8'hA5, 4'd7,  1'b1, 1'b0, 2'd1, 2'd0};
        tv[2] = '{12'hAA7, 8'hA5, 4'd8,  1'b1, 1'b0, 2'd2, 2'd0};
        tv[3] = '{12'h226, 8'h25, 4'd13, 1'b0, 1'b1, 2'd2, 2'd1};
        tv[4] = '{12'hA26, 8'hA5, 4'd1,  1'b1, 1'b0, 2'd3, 2'd1};
        tv[5] = '{12'h227, 8'hA5, 4'd12, 1'b1, 1'b0, 2'd3, 2'd1};
        tv[6] = '{12'hA23, 8'hA5, 4'd3,  1'b1, 1'b0, 2'd3, 2'd1};
        tv[7] = '{12'hAE7, 8'hAD, 4'd15, 1'b0, 1'b1, 2'd3, 2'd2};
        tv[8] = '{12'hF77, 8'hFF, 4'd0,  1'b0, 1'b0, 2'd3, 2'd2};

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_syndrome", o_syndrome, 0);
        chk("rst_flags", {o_err_corr, o_err_uncorr}, 0);
        chk("rst_cnts", {o_corr_cnt, o_uncorr_cnt}, 0);
        i_rst_n = 1'b1;
        tick;

        for (int i = 0; i < 9; i++) run_vec(tv[i], 1'b0, i);

        // clear coincides with a corrected handshake: clear wins
        v = '{12'h551, 8'h5A, 4'd1, 1'b1, 1'b0, 2'd0, 2'd0};
        run_vec(v, 1'b1, 9);
        v = '{12'h551, 8'h5A, 4'd1, 1'b1, 1'b0, 2'd1, 2'd0};
        run_vec(v, 1'b0, 10);

        bw = '{12'hA27, 12'h000, 12'hF77, 12'h550};
        bd = '{8'hA5, 8'h00, 8'hFF, 8'h5A};
        in_i = 0; out_i = 0; stalled = 1'b0; saw_full = 1'b0; held = '0;
        for (int c = 0; c < 20; c++) begin
            if (stalled) chk("stall_hold", o_data, held);
            i_ready = !(c >= 2 && c <= 4);
            i_valid = in_i < 4;
            i_code  = bw[in_i < 4 ? in_i : 0];
            #1;
            if (!o_ready) begin
                saw_full = 1'b1;
                chk("ready_low_needs_valid", o_valid, 1);
            end
            if (o_valid && i_ready) begin
                if (out_i < 4) begin
                    chk($sformatf("order[%0d]", out_i), o_data, bd[out_i]);
                    chk($sformatf("order_syn[%0d]", out_i), o_syndrome, 0);
                end else chk("extra_word", o_valid, 0);
                out_i++;
            end
            stalled = o_valid && !i_ready;
            held = o_data;
            if (i_valid && o_ready) in_i++;
            tick;
        end
        i_valid = 1'b0;
        chk("bp_delivered", out_i, 4);
        chk("bp_accepted", in_i, 4);
        chk("bp_ready_fell", saw_full, 1);

        // park a corrected word in S2, then reset asynchronously mid-cycle
        i_code = 12'h554; i_valid = 1'b1; i_ready = 1'b0;
        tick;
        i_valid = 1'b0;
        tick;
        chk("pre_rst_valid", o_valid, 1);
        chk("pre_rst_syn", o_syndrome, 3);
        chk("pre_rst_cnt", o_corr_cnt, 1);
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_data", o_data, 0);
        chk("arst_syndrome", o_syndrome, 0);
        chk("arst_flags", {o_err_corr, o_err_uncorr}, 0);
        chk("arst_cnts", {o_corr_cnt, o_uncorr_cnt}, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        tick;
        tick;
        chk("post_rst_no_word", o_valid, 0);
        chk("post_rst_cnt", o_corr_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
